// File: rtl/bnn_cls_pkg.sv
// Shared types for the BNN classification stage: Q8.8 score type, sequencer states
// and the most-negative score used to seed the runner-up tracker.
package bnn_cls_pkg;

    typedef logic signed [15:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } seq_state_t;

    localparam score_t SCORE_MIN = 16'sh8000;

endpackage

// File: rtl/argmax_accum.sv
// Running argmax over a frame of signed Q8.8 scores; ties keep the lowest index.
// With ARGMAX_MARGIN_EN defined it also tracks the runner-up score and exposes max - second.
module argmax_accum
    import bnn_cls_pkg::*;
#(
    parameter int IW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_beat,
    input  logic                i_first,
    input  logic [IW-1:0]       i_idx,
    input  logic signed [15:0]  i_score,
    output logic [IW-1:0]       o_idx_next
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [15:0]         o_margin_next
`endif
);

    score_t          r_max;
    logic [IW-1:0]   r_idx;
    score_t          w_max_next;
    logic [IW-1:0]   w_idx_next;
`ifdef ARGMAX_MARGIN_EN
    score_t          r_second;
    score_t          w_second_next;
`endif

    // Next-state values are exported so the sequencer can latch the final result
    // on the same edge that accepts the last beat.
    always_comb begin
        w_max_next    = r_max;
        w_idx_next    = r_idx;
`ifdef ARGMAX_MARGIN_EN
        w_second_next = r_second;
`endif
        if (i_beat) begin
            if (i_first) begin
                w_max_next    = i_score;
                w_idx_next    = '0;
`ifdef ARGMAX_MARGIN_EN
                w_second_next = SCORE_MIN;
`endif
            end else if (i_score > r_max) begin
                w_max_next    = i_score;
                w_idx_next    = i_idx;
`ifdef ARGMAX_MARGIN_EN
                w_second_next = r_max;
            end else if (i_score > r_second) begin
                w_second_next = i_score;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max    <= '0;
            r_idx    <= '0;
`ifdef ARGMAX_MARGIN_EN
            r_second <= '0;
`endif
        end else begin
            r_max    <= w_max_next;
            r_idx    <= w_idx_next;
`ifdef ARGMAX_MARGIN_EN
            r_second <= w_second_next;
`endif
        end
    end

    assign o_idx_next = w_idx_next;
`ifdef ARGMAX_MARGIN_EN
    // True difference is never above 16'hFFFF, so the wrapped 16-bit result is exact.
    assign o_margin_next = w_max_next - w_second_next;
`endif

endmodule

// File: rtl/argmax_sequencer.sv
// Final BNN classification controller: kicks the FC layer, scans IC scores, returns the argmax
// over a valid/ready result handshake. ARGMAX_MARGIN_EN adds a max-minus-runner-up margin port.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | accepting class scores, cnt = index of next beat
// DONE  | result_valid high, holding class_out until result_ready
module argmax_sequencer
    import bnn_cls_pkg::*;
#(
    parameter int IC         = 10,
    parameter int OUTPUT_BIT = $clog2(IC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    fc_start,
    input  logic                    score_valid,
    input  logic [15:0]             score,
    output logic                    score_ready,
    output logic [OUTPUT_BIT-1:0]   class_out,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    busy
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [15:0]             margin
`endif
);

    if (IC < 2) begin : g_ic_check
        $error("argmax_sequencer: IC must be >= 2");
    end

    localparam logic [OUTPUT_BIT-1:0] LAST = OUTPUT_BIT'(IC - 1);

    seq_state_t               r_state;
    logic [OUTPUT_BIT-1:0]    r_cnt;
    logic                     r_fc_start;
    logic                     r_score_ready;
    logic                     r_result_valid;
    logic                     r_busy;
    logic [OUTPUT_BIT-1:0]    r_class_out;
    logic [OUTPUT_BIT-1:0]    w_idx_next;
    logic                     w_beat;
`ifdef ARGMAX_MARGIN_EN
    logic [15:0]              r_margin;
    logic [15:0]              w_margin_next;
`endif

    assign w_beat = score_valid && r_score_ready;

    argmax_accum #(.IW(OUTPUT_BIT)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .i_beat     (w_beat),
        .i_first    (r_cnt == '0),
        .i_idx      (r_cnt),
        .i_score    (score),
        .o_idx_next (w_idx_next)
`ifdef ARGMAX_MARGIN_EN
        ,
        .o_margin_next (w_margin_next)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_fc_start     <= 1'b0;
            r_score_ready  <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_class_out    <= '0;
`ifdef ARGMAX_MARGIN_EN
            r_margin       <= '0;
`endif
        end else begin
            r_fc_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state       <= SCAN;
                        r_fc_start    <= 1'b1;
                        r_score_ready <= 1'b1;
                        r_busy        <= 1'b1;
                        r_cnt         <= '0;
                    end
                end
                SCAN: begin
                    if (w_beat) begin
                        if (r_cnt == LAST) begin
                            r_state        <= DONE;
                            r_score_ready  <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_class_out    <= w_idx_next;
`ifdef ARGMAX_MARGIN_EN
                            r_margin       <= w_margin_next;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        // Back-to-back frames: a start coinciding with the ack skips IDLE.
                        if (start) begin
                            r_state       <= SCAN;
                            r_fc_start    <= 1'b1;
                            r_score_ready <= 1'b1;
                            r_cnt         <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fc_start     = r_fc_start;
    assign score_ready  = r_score_ready;
    assign class_out    = r_class_out;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
`ifdef ARGMAX_MARGIN_EN
    assign margin       = r_margin;
`endif

endmodule

// File: tb/tb_argmax_sequencer.sv
// Self-checking bench for argmax_sequencer (IC=10): directed and random frames against an
// array/queue reference model. Margin checks are included when ARGMAX_MARGIN_EN is defined.
module tb_argmax_sequencer;

    localparam int IC = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic        fc_start;
    logic        score_valid;
    logic [15:0] score;
    logic        score_ready;
    logic [3:0]  class_out;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
`ifdef ARGMAX_MARGIN_EN
    logic [15:0] margin;
`endif

    argmax_sequencer #(.IC(IC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fc_start     (fc_start),
        .score_valid  (score_valid),
        .score        (score),
        .score_ready  (score_ready),
        .class_out    (class_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin       (margin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic signed [15:0] fr [IC];
    int e_idx;
    int e_margin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: best value first, then the first class holding it; margin from a sorted copy.
    task automatic compute_expected();
        int m;
        int q[$];
        m = fr[0];
        for (int i = 1; i < IC; i++) if (int'(fr[i]) > m) m = fr[i];
        e_idx = -1;
        for (int i = 0; i < IC; i++) if (e_idx < 0 && int'(fr[i]) == m) e_idx = i;
        q = {};
        for (int i = 0; i < IC; i++) q.push_back(int'(fr[i]));
        q.rsort();
        e_margin = q[0] - q[1];
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fc_start_pulse", 32'(fc_start), 1);
        check("busy_scan", 32'(busy), 1);
        check("score_ready_first", 32'(score_ready), 1);
        check("rv_scan_entry", 32'(result_valid), 0);
    endtask

    task automatic feed(input int nbeats, input int gap_pct);
        int k;
        int cyc;
        logic v;
        k = 0;
        cyc = 0;
        while (k < nbeats && cyc < 400) begin
            v = ($urandom_range(99) >= gap_pct);
            check("score_ready_scan", 32'(score_ready), 1);
            score_valid = v;
            score = fr[k];
            tick();
            cyc++;
            if (v) k++;
            check("fc_start_single", 32'(fc_start), 0);
            if (k < IC) check("rv_low_in_scan", 32'(result_valid), 0);
        end
        score_valid = 1'b0;
        score = 16'h0;
        check("feed_beats", 32'(k), 32'(nbeats));
    endtask

    task automatic check_result(input string tag);
        check({tag, "_rv"}, 32'(result_valid), 1);
        check({tag, "_class"}, 32'(class_out), 32'(e_idx));
        check({tag, "_sr_done"}, 32'(score_ready), 0);
        check({tag, "_busy"}, 32'(busy), 1);
`ifdef ARGMAX_MARGIN_EN
        check({tag, "_margin"}, 32'(margin), 32'(e_margin[15:0]));
`endif
    endtask

    task automatic hold(input int n);
        result_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            score_valid = 1'($urandom);
            score = 16'($urandom);
            tick();
            check("hold_rv", 32'(result_valid), 1);
            check("hold_class", 32'(class_out), 32'(e_idx));
            check("hold_sr", 32'(score_ready), 0);
        end
        score_valid = 1'b0;
    endtask

    task automatic ack();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("ack_rv", 32'(result_valid), 0);
        check("ack_busy", 32'(busy), 0);
        check("ack_sr", 32'(score_ready), 0);
        tick();
        check("idle_class_kept", 32'(class_out), 32'(e_idx));
    endtask

    task automatic full_frame(input string tag, input int gap_pct, input int nhold);
        compute_expected();
        begin_frame();
        feed(IC, gap_pct);
        check_result(tag);
        hold(nhold);
        ack();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        score_valid = 1'b0;
        score = 16'h0;
        result_ready = 1'b0;
        tick();
        tick();
        check("rst_fc_start", 32'(fc_start), 0);
        check("rst_score_ready", 32'(score_ready), 0);
        check("rst_class", 32'(class_out), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Ascending scores, back-to-back beats.
        for (int i = 0; i < IC; i++) fr[i] = 16'(i * 256);
        full_frame("ascend", 0, 0);

        // Tie for the maximum resolves to the lowest index.
        fr[0] = 16'sh0500; fr[1] = 16'sh0700; fr[2] = 16'sh0700; fr[3] = -16'sh0300;
        fr[4] = 16'sh0000; fr[5] = 16'sh0100; fr[6] = 16'sh0200; fr[7] = 16'sh0300;
        fr[8] = 16'sh0400; fr[9] = 16'sh0700;
        full_frame("tie", 0, 1);

        // Unique max 7 against runner-up 5.
        fr[0] = 16'sh0500; fr[1] = 16'sh0700; fr[2] = -16'sh0300; fr[3] = 16'sh0000;
        fr[4] = 16'sh0100; fr[5] = 16'sh0200; fr[6] = 16'sh0300; fr[7] = 16'sh0400;
        fr[8] = -16'sh0100; fr[9] = -16'sh0200;
        full_frame("uniq", 0, 0);

        // All most-negative except class 6.
        for (int i = 0; i < IC; i++) fr[i] = 16'sh8000;
        fr[6] = 16'shFF00;
        full_frame("allneg", 0, 0);

        // Random scores with stalls and a slow consumer.
        for (int i = 0; i < IC; i++) fr[i] = 16'($urandom);
        full_frame("bp", 50, 5);

        // start held through SCAN and an unacked DONE, then ack+start chains a second frame.
        for (int i = 0; i < IC; i++) fr[i] = 16'($urandom);
        compute_expected();
        begin_frame();
        start = 1'b1;
        feed(IC, 30);
        check_result("chain1");
        hold(3);
        check("chain_fc_hold", 32'(fc_start), 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check("chain_rv_drop", 32'(result_valid), 0);
        check("chain_busy", 32'(busy), 1);
        check("chain_fc_start", 32'(fc_start), 1);
        check("chain_sr", 32'(score_ready), 1);
        for (int i = 0; i < IC; i++) fr[i] = 16'($urandom);
        compute_expected();
        feed(IC, 20);
        check_result("chain2");
        ack();

        // Reset after 4 beats abandons the frame.
        for (int i = 0; i < IC; i++) fr[i] = 16'($urandom);
        begin_frame();
        feed(4, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rv", 32'(result_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_sr", 32'(score_ready), 0);
        check("midrst_class", 32'(class_out), 0);
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1;
            score = 16'($urandom);
            tick();
            check("midrst_rv_stays", 32'(result_valid), 0);
        end
        score_valid = 1'b0;
        for (int i = 0; i < IC; i++) fr[i] = 16'($urandom);
        full_frame("after_rst", 10, 1);

        // Random frames, half of them drawn from a narrow range to provoke ties.
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < IC; i++) begin
                if (f % 2 == 0) fr[i] = 16'($urandom);
                else fr[i] = 16'(($urandom_range(4) - 2) * 256);
            end
            full_frame("rand", $urandom_range(60), $urandom_range(4));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
